csr_file_m: RTL and testbench

- Parametrised machine-mode CSR file for the RV32 pipelined core; next generation of the current 16-entry CSR block.
- Adds N write ports, full trap entry/exit (mepc/mcause/mtval capture), interrupt enable/pending logic, 64-bit cycle/instret counters and vectored mtvec target generation.
- Sits beside the register file: read in ID, written from WB ports and the trap controller.

---
 rtl/csr_pkg.sv | 39 +++
 rtl/csr_counter64.sv | 35 +++
 rtl/csr_file_m.sv | 238 +++++++++++++++++++++++
 tb/tb_csr_file_m.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR file: addresses, write modes,
// bit positions inside mstatus/mie/mip and the fixed misa value.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MISA     = 12'h301;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH= 12'hB82;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    typedef enum logic [1:0] {
        CSR_NOP = 2'b00,
        CSR_W   = 2'b01,
        CSR_S   = 2'b10,
        CSR_C   = 2'b11
    } csr_mode_e;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam int MIP_MSIP = 3;
    localparam int MIP_MTIP = 7;
    localparam int MIP_MEIP = 11;

    localparam logic [31:0] MIE_WMASK = 32'h0000_0888;
    localparam logic [31:0] MISA_VAL  = 32'h4000_0100;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter with per-half overwrite. Any half write freezes the
// increment for that cycle so software sees exactly the value it wrote.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    input  logic        wrLo_i,
    input  logic        wrHi_i,
    input  logic [31:0] dataLo_i,
    input  logic [31:0] dataHi_i,
    output logic [63:0] count_o
);

    logic [63:0] count_q;
    logic [63:0] count_d;

    // Next count: written halves replace the old ones, otherwise increment.
    always_comb begin
        count_d = count_q + {63'd0, inc_i};
        if (wrLo_i || wrHi_i) begin
            count_d = count_q;
            if (wrLo_i) count_d[31:0]  = dataLo_i;
            if (wrHi_i) count_d[63:32] = dataHi_i;
        end
    end

    // Counter state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/csr_file_m.sv
// Machine-mode CSR file: multi-port read/modify/write, trap entry/exit,
// interrupt enable/pending, 64-bit cycle/instret counters, vectored mtvec.
module csr_file_m
    import csr_pkg::*;
#(
    parameter int unsigned      XLEN        = 32,
    parameter int unsigned      NUM_WPORTS  = 2,
    parameter logic [XLEN-1:0]  HART_ID     = '0,
    parameter logic [XLEN-1:0]  MSTATUS_RST = XLEN'(32'h88),
    parameter logic [XLEN-1:0]  MTVEC_RST   = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [11:0]                raddr_i,
    output logic [XLEN-1:0]            rdata_o,
    output logic                       raddr_ok_o,
    input  logic [NUM_WPORTS-1:0]      wen_i,
    input  logic [12*NUM_WPORTS-1:0]   waddr_i,
    input  logic [XLEN*NUM_WPORTS-1:0] wdata_i,
    input  logic [2*NUM_WPORTS-1:0]    wmode_i,
    input  logic                       trap_begin_i,
    input  logic [XLEN-1:0]            trap_cause_i,
    input  logic [XLEN-1:0]            trap_pc_i,
    input  logic [XLEN-1:0]            trap_val_i,
    input  logic                       trap_end_i,
    input  logic                       instret_inc_i,
    input  logic                       irq_ext_i,
    input  logic                       irq_timer_i,
    input  logic                       irq_sw_i,
    output logic                       irq_take_o,
    output logic [XLEN-1:0]            trap_target_o,
    output logic [XLEN-1:0]            mstatus_o,
    output logic [XLEN-1:0]            mtvec_o,
    output logic [XLEN-1:0]            mepc_o
);

    function automatic logic [XLEN-1:0] applyMode(input csr_mode_e mode,
                                                  input logic [XLEN-1:0] cur,
                                                  input logic [XLEN-1:0] data);
        case (mode)
            CSR_W:   return data;
            CSR_S:   return cur | data;
            CSR_C:   return cur & ~data;
            default: return cur;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] statusView(input logic mieBit, input logic mpieBit);
        logic [XLEN-1:0] v;
        v = '0;
        v[MSTATUS_MIE]  = mieBit;
        v[MSTATUS_MPIE] = mpieBit;
        v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return v;
    endfunction

    logic            statusMie_q, statusMie_d, statusMpie_q, statusMpie_d;
    logic [XLEN-1:0] mieReg_q, mieReg_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
    logic            mipExt_q, mipTimer_q, mipSw_q;
    logic [XLEN-1:0] mipView, statusNow;

    logic            statusMieRun, statusMpieRun;
    logic [XLEN-1:0] mieRegRun, mtvecRun, mscratchRun, mepcRun, mcauseRun, mtvalRun;
    logic [31:0]     cycLoRun, cycHiRun, insLoRun, insHiRun;
    logic            cycLoWr, cycHiWr, insLoWr, insHiWr;
    logic [11:0]     portAddr;
    logic [XLEN-1:0] portData, newVal;
    csr_mode_e       portMode;

    logic [63:0]     mcycle, minstret;
    logic [XLEN-1:0] tvecBase;

    assign statusNow = statusView(statusMie_q, statusMpie_q);
    always_comb begin
        mipView = '0;
        mipView[MIP_MEIP] = mipExt_q;
        mipView[MIP_MTIP] = mipTimer_q;
        mipView[MIP_MSIP] = mipSw_q;
    end

    // Apply write ports in ascending order, each seeing its predecessor's result.
    always_comb begin
        statusMieRun  = statusMie_q;
        statusMpieRun = statusMpie_q;
        mieRegRun     = mieReg_q;
        mtvecRun      = mtvec_q;
        mscratchRun   = mscratch_q;
        mepcRun       = mepc_q;
        mcauseRun     = mcause_q;
        mtvalRun      = mtval_q;
        cycLoRun = mcycle[31:0];   cycHiRun = mcycle[63:32];
        insLoRun = minstret[31:0]; insHiRun = minstret[63:32];
        cycLoWr = 1'b0; cycHiWr = 1'b0; insLoWr = 1'b0; insHiWr = 1'b0;
        portAddr = '0;
        portData = '0;
        portMode = CSR_NOP;
        newVal   = '0;
        for (int i = 0; i < NUM_WPORTS; i++) begin
            portAddr = waddr_i[12*i +: 12];
            portData = wdata_i[XLEN*i +: XLEN];
            portMode = csr_mode_e'(wmode_i[2*i +: 2]);
            if (wen_i[i] && portMode != CSR_NOP) begin
                case (portAddr)
                    CSR_MSTATUS: begin
                        newVal = applyMode(portMode, statusView(statusMieRun, statusMpieRun), portData);
                        statusMieRun  = newVal[MSTATUS_MIE];
                        statusMpieRun = newVal[MSTATUS_MPIE];
                    end
                    CSR_MIE:      mieRegRun   = applyMode(portMode, mieRegRun, portData) & XLEN'(MIE_WMASK);
                    CSR_MTVEC:    mtvecRun    = applyMode(portMode, mtvecRun, portData);
                    CSR_MSCRATCH: mscratchRun = applyMode(portMode, mscratchRun, portData);
                    CSR_MEPC:     mepcRun     = applyMode(portMode, mepcRun, portData) & ~XLEN'(3);
                    CSR_MCAUSE:   mcauseRun   = applyMode(portMode, mcauseRun, portData);
                    CSR_MTVAL:    mtvalRun    = applyMode(portMode, mtvalRun, portData);
                    CSR_MCYCLE: begin
                        newVal = applyMode(portMode, XLEN'(cycLoRun), portData);
                        cycLoRun = 32'(newVal); cycLoWr = 1'b1;
                    end
                    CSR_MCYCLEH: begin
                        newVal = applyMode(portMode, XLEN'(cycHiRun), portData);
                        cycHiRun = 32'(newVal); cycHiWr = 1'b1;
                    end
                    CSR_MINSTRET: begin
                        newVal = applyMode(portMode, XLEN'(insLoRun), portData);
                        insLoRun = 32'(newVal); insLoWr = 1'b1;
                    end
                    CSR_MINSTRETH: begin
                        newVal = applyMode(portMode, XLEN'(insHiRun), portData);
                        insHiRun = 32'(newVal); insHiWr = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Trap entry beats trap exit, and both beat software writes to the trap CSRs.
    always_comb begin
        statusMie_d  = statusMieRun;
        statusMpie_d = statusMpieRun;
        mieReg_d     = mieRegRun;
        mtvec_d      = mtvecRun;
        mscratch_d   = mscratchRun;
        mepc_d       = mepcRun;
        mcause_d     = mcauseRun;
        mtval_d      = mtvalRun;
        if (trap_begin_i) begin
            mepc_d       = trap_pc_i & ~XLEN'(3);
            mcause_d     = trap_cause_i;
            mtval_d      = trap_val_i;
            statusMpie_d = statusMie_q;
            statusMie_d  = 1'b0;
        end else if (trap_end_i) begin
            statusMie_d  = statusMpie_q;
            statusMpie_d = 1'b1;
        end
    end

    // CSR state registers and the one-cycle interrupt pending sampler.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            statusMie_q  <= MSTATUS_RST[MSTATUS_MIE];
            statusMpie_q <= MSTATUS_RST[MSTATUS_MPIE];
            mieReg_q     <= '0;
            mtvec_q      <= MTVEC_RST;
            mscratch_q   <= '0;
            mepc_q       <= '0;
            mcause_q     <= '0;
            mtval_q      <= '0;
            mipExt_q     <= 1'b0;
            mipTimer_q   <= 1'b0;
            mipSw_q      <= 1'b0;
        end else begin
            statusMie_q  <= statusMie_d;
            statusMpie_q <= statusMpie_d;
            mieReg_q     <= mieReg_d;
            mtvec_q      <= mtvec_d;
            mscratch_q   <= mscratch_d;
            mepc_q       <= mepc_d;
            mcause_q     <= mcause_d;
            mtval_q      <= mtval_d;
            mipExt_q     <= irq_ext_i;
            mipTimer_q   <= irq_timer_i;
            mipSw_q      <= irq_sw_i;
        end
    end

    csr_counter64 uCycle (
        .clk(clk), .rst(rst), .inc_i(1'b1),
        .wrLo_i(cycLoWr), .wrHi_i(cycHiWr),
        .dataLo_i(cycLoRun), .dataHi_i(cycHiRun), .count_o(mcycle)
    );

    csr_counter64 uInstret (
        .clk(clk), .rst(rst), .inc_i(instret_inc_i),
        .wrLo_i(insLoWr), .wrHi_i(insHiWr),
        .dataLo_i(insLoRun), .dataHi_i(insHiRun), .count_o(minstret)
    );

    // Combinational read mux; shows pre-edge state, no write bypass.
    always_comb begin
        rdata_o    = '0;
        raddr_ok_o = 1'b1;
        case (raddr_i)
            CSR_MSTATUS:   rdata_o = statusNow;
            CSR_MISA:      rdata_o = XLEN'(MISA_VAL);
            CSR_MIE:       rdata_o = mieReg_q;
            CSR_MTVEC:     rdata_o = mtvec_q;
            CSR_MSCRATCH:  rdata_o = mscratch_q;
            CSR_MEPC:      rdata_o = mepc_q;
            CSR_MCAUSE:    rdata_o = mcause_q;
            CSR_MTVAL:     rdata_o = mtval_q;
            CSR_MIP:       rdata_o = mipView;
            CSR_MCYCLE:    rdata_o = XLEN'(mcycle[31:0]);
            CSR_MCYCLEH:   rdata_o = XLEN'(mcycle[63:32]);
            CSR_MINSTRET:  rdata_o = XLEN'(minstret[31:0]);
            CSR_MINSTRETH: rdata_o = XLEN'(minstret[63:32]);
            CSR_MHARTID:   rdata_o = HART_ID;
            default:       raddr_ok_o = 1'b0;
        endcase
    end

    // Vectored mode only redirects asynchronous causes; exceptions use the base.
    always_comb begin
        tvecBase = {mtvec_q[XLEN-1:2], 2'b00};
        if (mtvec_q[1:0] == 2'b01 && trap_cause_i[XLEN-1])
            trap_target_o = tvecBase + XLEN'({trap_cause_i[4:0], 2'b00});
        else
            trap_target_o = tvecBase;
    end

    assign irq_take_o = statusMie_q & (|(mieReg_q & mipView));
    assign mstatus_o  = statusNow;
    assign mtvec_o    = mtvec_q;
    assign mepc_o     = mepc_q;

endmodule

// File: tb/tb_csr_file_m.sv
// Directed bench for csr_file_m: expectations are queued as stimulus is
// driven and drained in the low clock phase after the relevant edge.
module tb_csr_file_m;

    localparam int XLEN = 32;
    localparam int NWP  = 2;
    localparam int K_RDATA = 0, K_OK = 1, K_IRQ = 2, K_TGT = 3, K_STAT = 4, K_MEPC = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [11:0]          raddr_i;
    logic [XLEN-1:0]      rdata_o;
    logic                 raddr_ok_o;
    logic [NWP-1:0]       wen_i;
    logic [12*NWP-1:0]    waddr_i;
    logic [XLEN*NWP-1:0]  wdata_i;
    logic [2*NWP-1:0]     wmode_i;
    logic                 trap_begin_i, trap_end_i, instret_inc_i;
    logic [XLEN-1:0]      trap_cause_i, trap_pc_i, trap_val_i;
    logic                 irq_ext_i, irq_timer_i, irq_sw_i;
    logic                 irq_take_o;
    logic [XLEN-1:0]      trap_target_o, mstatus_o, mtvec_o, mepc_o;

    typedef struct {
        string       tag;
        int          kind;
        logic [11:0] addr;
        logic [31:0] exp;
    } exp_t;

    exp_t sbQ[$];
    int   checks = 0;
    int   errors = 0;

    csr_file_m #(.XLEN(XLEN), .NUM_WPORTS(NWP)) dut (
        .clk(clk), .rst(rst),
        .raddr_i(raddr_i), .rdata_o(rdata_o), .raddr_ok_o(raddr_ok_o),
        .wen_i(wen_i), .waddr_i(waddr_i), .wdata_i(wdata_i), .wmode_i(wmode_i),
        .trap_begin_i(trap_begin_i), .trap_cause_i(trap_cause_i),
        .trap_pc_i(trap_pc_i), .trap_val_i(trap_val_i), .trap_end_i(trap_end_i),
        .instret_inc_i(instret_inc_i),
        .irq_ext_i(irq_ext_i), .irq_timer_i(irq_timer_i), .irq_sw_i(irq_sw_i),
        .irq_take_o(irq_take_o), .trap_target_o(trap_target_o),
        .mstatus_o(mstatus_o), .mtvec_o(mtvec_o), .mepc_o(mepc_o)
    );

    // Slow clock leaves room for several #1-spaced reads in each low phase.
    always #50 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expectVal(input string tag, input int kind,
                             input logic [11:0] addr, input logic [31:0] exp);
        exp_t e;
        e.tag = tag; e.kind = kind; e.addr = addr; e.exp = exp;
        sbQ.push_back(e);
    endtask

    task automatic applyStimulus(input int port, input logic [11:0] addr,
                                 input logic [31:0] data, input logic [1:0] mode);
        wen_i[port]             = 1'b1;
        waddr_i[12*port +: 12]  = addr;
        wdata_i[XLEN*port +: XLEN] = data;
        wmode_i[2*port +: 2]    = mode;
    endtask

    task automatic clearInputs();
        wen_i = '0; waddr_i = '0; wdata_i = '0; wmode_i = '0;
        trap_begin_i = 1'b0; trap_end_i = 1'b0; instret_inc_i = 1'b0;
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [31:0] obs;
        while (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            raddr_i = e.addr;
            #1;
            case (e.kind)
                K_RDATA: obs = rdata_o;
                K_OK:    obs = {31'd0, raddr_ok_o};
                K_IRQ:   obs = {31'd0, irq_take_o};
                K_TGT:   obs = trap_target_o;
                K_STAT:  obs = mstatus_o;
                default: obs = mepc_o;
            endcase
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        raddr_i = '0;
        trap_cause_i = '0; trap_pc_i = '0; trap_val_i = '0;
        irq_ext_i = 1'b0; irq_timer_i = 1'b0; irq_sw_i = 1'b0;
        clearInputs();

        // Reset state
        tick();
        expectVal("rst_mstatus", K_RDATA, 12'h300, 32'h1888);
        expectVal("rst_mtvec",   K_RDATA, 12'h305, 32'h0);
        expectVal("rst_hartid",  K_RDATA, 12'hF14, 32'h0);
        expectVal("rst_misa",    K_RDATA, 12'h301, 32'h40000100);
        expectVal("unmap_rdata", K_RDATA, 12'h7C0, 32'h0);
        expectVal("unmap_ok",    K_OK,    12'h7C0, 32'h0);
        expectVal("map_ok",      K_OK,    12'h300, 32'h1);
        expectVal("rst_mepc_o",  K_MEPC,  12'h000, 32'h0);
        expectVal("rst_irq",     K_IRQ,   12'h000, 32'h0);
        checkOutput();
        rst = 1'b0;
        tick();

        // Ordered ports: write then set on mscratch
        applyStimulus(0, 12'h340, 32'hF0, 2'b01);
        applyStimulus(1, 12'h340, 32'h0F, 2'b10);
        expectVal("no_bypass", K_RDATA, 12'h340, 32'h0);
        checkOutput();
        tick();
        expectVal("wr_then_set", K_RDATA, 12'h340, 32'hFF);
        checkOutput();
        clearInputs();

        // Set then clear, plus writes to RO misa and unmapped address dropped
        applyStimulus(0, 12'h340, 32'h100, 2'b10);
        applyStimulus(1, 12'h340, 32'hF0, 2'b11);
        tick();
        expectVal("set_then_clr", K_RDATA, 12'h340, 32'h10F);
        checkOutput();
        clearInputs();
        applyStimulus(0, 12'h301, 32'h0, 2'b01);
        applyStimulus(1, 12'h304, 32'hFFFFFFFF, 2'b01);
        tick();
        expectVal("misa_ro",  K_RDATA, 12'h301, 32'h40000100);
        expectVal("mie_mask", K_RDATA, 12'h304, 32'h888);
        checkOutput();
        clearInputs();
        applyStimulus(0, 12'h341, 32'h1237, 2'b01);
        applyStimulus(1, 12'h305, 32'h101, 2'b01);
        tick();
        expectVal("mepc_align", K_RDATA, 12'h341, 32'h1234);
        expectVal("mtvec_wr",   K_RDATA, 12'h305, 32'h101);
        checkOutput();
        clearInputs();

        // Trap entry (MIE=1 from reset), with a competing mcause write
        trap_cause_i = 32'h0000000B;
        expectVal("tgt_sync", K_TGT, 12'h000, 32'h100);
        checkOutput();
        trap_cause_i = 32'h8000000B; trap_pc_i = 32'h1006; trap_val_i = 32'h5;
        trap_begin_i = 1'b1;
        applyStimulus(0, 12'h342, 32'h55, 2'b01);
        expectVal("tgt_vec", K_TGT, 12'h000, 32'h12C);
        checkOutput();
        tick();
        expectVal("trap_mepc",   K_RDATA, 12'h341, 32'h1004);
        expectVal("trap_mcause", K_RDATA, 12'h342, 32'h8000000B);
        expectVal("trap_mtval",  K_RDATA, 12'h343, 32'h5);
        expectVal("trap_status", K_STAT,  12'h000, 32'h1880);
        expectVal("trap_mepc_o", K_MEPC,  12'h000, 32'h1004);
        checkOutput();
        clearInputs();

        // mret restores MIE from MPIE and overrides a mstatus write
        trap_end_i = 1'b1;
        applyStimulus(0, 12'h300, 32'h0, 2'b01);
        tick();
        expectVal("mret_status", K_RDATA, 12'h300, 32'h1888);
        checkOutput();
        clearInputs();

        // Simultaneous begin/end from MIE=0, MPIE=1: entry result only
        applyStimulus(0, 12'h300, 32'h80, 2'b01);
        tick();
        expectVal("pre_both", K_RDATA, 12'h300, 32'h1880);
        checkOutput();
        clearInputs();
        trap_begin_i = 1'b1; trap_end_i = 1'b1;
        trap_cause_i = 32'h2; trap_pc_i = 32'h2000; trap_val_i = 32'h7;
        tick();
        expectVal("both_status", K_RDATA, 12'h300, 32'h1800);
        expectVal("both_mcause", K_RDATA, 12'h342, 32'h2);
        expectVal("both_mepc",   K_RDATA, 12'h341, 32'h2000);
        checkOutput();
        clearInputs();

        // Interrupt path: mie.MTIE and MIE, timer pending has one cycle latency
        applyStimulus(0, 12'h304, 32'h80, 2'b01);
        applyStimulus(1, 12'h300, 32'h8, 2'b01);
        tick();
        clearInputs();
        irq_ext_i = 1'b1;
        irq_timer_i = 1'b1;
        expectVal("irq_pre", K_IRQ, 12'h000, 32'h0);
        checkOutput();
        tick();
        expectVal("irq_take", K_IRQ,   12'h000, 32'h1);
        expectVal("mip_read", K_RDATA, 12'h344, 32'h880);
        checkOutput();
        applyStimulus(0, 12'h300, 32'h8, 2'b11);
        tick();
        expectVal("irq_drop", K_IRQ, 12'h000, 32'h0);
        checkOutput();
        clearInputs();
        irq_ext_i = 1'b0;
        irq_timer_i = 1'b0;

        // mcycle wrap
        applyStimulus(0, 12'hB00, 32'hFFFFFFFF, 2'b01);
        applyStimulus(1, 12'hB80, 32'hFFFFFFFF, 2'b01);
        tick();
        clearInputs();
        expectVal("cyc_lo_max", K_RDATA, 12'hB00, 32'hFFFFFFFF);
        expectVal("cyc_hi_max", K_RDATA, 12'hB80, 32'hFFFFFFFF);
        checkOutput();
        tick();
        expectVal("cyc_lo_wrap", K_RDATA, 12'hB00, 32'h0);
        expectVal("cyc_hi_wrap", K_RDATA, 12'hB80, 32'h0);
        checkOutput();
        tick();
        expectVal("cyc_lo_inc", K_RDATA, 12'hB00, 32'h1);
        checkOutput();

        // minstret counts only pulses
        for (int n = 0; n < 7; n++) begin
            instret_inc_i = 1'b1;
            tick();
            instret_inc_i = 1'b0;
            tick();
        end
        expectVal("instret_7",  K_RDATA, 12'hB02, 32'h7);
        expectVal("instret_hi", K_RDATA, 12'hB82, 32'h0);
        checkOutput();

        // Half write suppresses the increment; other half untouched
        instret_inc_i = 1'b1;
        applyStimulus(0, 12'hB02, 32'd100, 2'b01);
        tick();
        expectVal("inst_wr_sup", K_RDATA, 12'hB02, 32'd100);
        checkOutput();
        clearInputs();
        instret_inc_i = 1'b1;
        applyStimulus(0, 12'hB82, 32'h1, 2'b01);
        tick();
        expectVal("inst_hi_wr", K_RDATA, 12'hB82, 32'h1);
        expectVal("inst_lo_kept", K_RDATA, 12'hB02, 32'd100);
        checkOutput();
        clearInputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
